scan_chain_driver: RTL and testbench
====================================

// Module: scan_chain_driver
// PURPOSE
//  Controller end of the per-slot scan chain feeding user designs' io_in/io_out.
//  Accepts a (slot, input byte) request, serially shifts all slot input bytes into the chain,
//  latches them onto io_in, captures io_out of every slot, shifts it back, returns the selected
//  slot's output byte. Sits between host/logic-analyser logic and the chain of user_module slots.
// PARAMETERS
//  NUM_SLOTS  4  slots on the chain; chain length T = NUM_SLOTS*8 bits
//  CLK_DIV    2  scan_clk half-period in clk cycles (>=1); one scan bit = 2*CLK_DIV clk cycles
// PORTS
//  clk            in   1   system clock
//  rst_n          in   1   async active-low reset
//  req_valid      in   1   request present
//  req_ready      out  1   request accepted when req_valid&&req_ready
//  req_slot       in   SW  target slot, SW=max(1,$clog2(NUM_SLOTS))
//  req_data       in   8   byte to apply to io_in of req_slot
//  rsp_valid      out  1   response present
//  rsp_ready      in   1   response consumed when rsp_valid&&rsp_ready
//  rsp_data       out  8   captured io_out of req_slot
//  scan_clk       out  1   chain shift/capture clock
//  scan_data_out  out  1   serial data into slot 0
//  scan_select    out  1   0=shift, 1=capture io_out into chain
//  scan_latch_en  out  1   transfers chain contents to all slots' io_in
//  scan_data_in   in   1   serial data from last slot
// BEHAVIOUR
//  - Reset: FSM=IDLE, req_ready=1, rsp_valid=0, rsp_data=0, scan_clk/data_out/select/latch_en=0,
//    shadow bytes cleared to 0x00. Reset mid-transaction aborts instantly; chain contents undefined.
//  - Shadow: one byte per slot holding last requested value; unselected slots re-sent unchanged.
//  - FSM: IDLE -> SHIFT_IN -> LATCH -> CAPTURE -> SHIFT_OUT -> RESP -> IDLE.
//    IDLE: req_ready=1 only here; on accept, write shadow[req_slot], register slot, go SHIFT_IN.
//    SHIFT_IN: T bits, stream = {shadow[N-1],...,shadow[0]} each MSB-first; data changes only
//      while scan_clk low (on falling-edge strobe), stable across rising edge.
//    LATCH: scan_latch_en=1 for one full scan period (2*CLK_DIV cycles), scan_clk held low.
//    CAPTURE: scan_select=1 for one scan period containing exactly one scan_clk rise.
//    SHIFT_OUT: scan_select=0, T scan_clk pulses, scan_data_out=0; scan_data_in sampled in the
//      clk cycle of each rising edge; returned stream ordered as in SHIFT_IN.
//    RESP: rsp_valid=1, rsp_data = returned byte of registered slot, both stable until rsp_ready.
//  - Latency: accept edge to rsp_valid high = (2T+2)*2*CLK_DIV + 2 clk cycles (266 at defaults).
//  - req_slot >= NUM_SLOTS: accepted, no shadow write, full sequence runs, rsp_data=0x00.
//  - scan_clk: 50% duty, starts low each phase; no scan_clk pulses in IDLE, LATCH or RESP.
//  - Bit counter wraps never: phase ends exactly at T bits; counter width $clog2(T+1).
// CONFIGURATION
//  SCAN_CHAIN_DRIVER_TXN_COUNT_EN: defined -> extra port txn_count out 16, counts completed
//    rsp handshakes, reset 0, wraps 0xFFFF->0x0000. Undefined -> port and counter absent.
// STRUCTURE
//  - Package scan_pkg: FSM state enum, SLOT_W=8 localparam, txn_count width.
//  - Sub-module scan_clk_gen: CLK_DIV divider; outputs scan_clk, rise/fall strobes; enable input.
// TESTING (NUM_SLOTS=4, CLK_DIV=2; chain model: each slot io_out = ~io_in)
//  1 reset: rst_n=0 -> all outputs 0 except req_ready=1; no scan_clk toggles for 50 cycles.
//  2 req slot2=0xA5 -> model latches {00,A5,00,00}; rsp_data=0x5A at cycle 266 after accept.
//  3 slot0=0x3C then slot1=0x0F -> 2nd latch {00,00,0F,3C}; rsp_data=0xF0.
//  4 rsp_ready=0 for 100 cycles -> rsp_valid/rsp_data stable, req_ready=0; then completes.
//  5 rst_n low at SHIFT_IN bit 10 -> outputs reset, shadow 0; next req slot3=0x81 -> rsp 0x7E.
//  6 req_slot=3 with NUM_SLOTS=3 -> no shadow change, rsp_data=0x00; macro on: txn_count+1.

Source files
------------

// File: rtl/scan_chain_driver_pkg.sv
// Shared types and constants for the scan chain driver (package scan_pkg).
// Optional transaction counter is enabled with SCAN_CHAIN_DRIVER_TXN_COUNT_EN.
package scan_pkg;
    localparam int SLOT_W    = 8;
    localparam int TXN_CNT_W = 16;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SHIFT_IN,
        ST_LATCH,
        ST_CAPTURE,
        ST_SHIFT_OUT,
        ST_RESP
    } state_t;
endpackage

// File: rtl/scan_chain_driver_if.sv
// Request/response handshake between the host side and the scan chain driver.
interface scan_chain_driver_if #(
    parameter int NUM_SLOTS = 4
);
    import scan_pkg::*;
    localparam int SW = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;

    logic              req_valid;
    logic              req_ready;
    logic [SW-1:0]     req_slot;
    logic [SLOT_W-1:0] req_data;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [SLOT_W-1:0] rsp_data;

    modport master (
        output req_valid, req_slot, req_data, rsp_ready,
        input  req_ready, rsp_valid, rsp_data
    );

    modport slave (
        input  req_valid, req_slot, req_data, rsp_ready,
        output req_ready, rsp_valid, rsp_data
    );
endinterface

// File: rtl/scan_chain_driver_scan_clk_gen.sv
// Divides clk into scan_clk (CLK_DIV clk cycles per half-period) with rise/fall strobes.
module scan_clk_gen #(
    parameter int CLK_DIV = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_en,
    input  logic i_hold,
    output logic o_scan_clk,
    output logic o_rise,
    output logic o_fall
);
    localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    logic [CW-1:0] r_cnt;
    logic          r_phase;
    logic          r_clk;
    logic          w_term;

    assign w_term     = i_en && (r_cnt == CW'(CLK_DIV - 1));
    assign o_rise     = w_term && !r_phase;
    assign o_fall     = w_term && r_phase;
    assign o_scan_clk = r_clk;

    // r_phase keeps period timing while i_hold forces the visible clock low
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt   <= '0;
            r_phase <= 1'b0;
            r_clk   <= 1'b0;
        end else if (!i_en) begin
            r_cnt   <= '0;
            r_phase <= 1'b0;
            r_clk   <= 1'b0;
        end else if (w_term) begin
            r_cnt   <= '0;
            r_phase <= ~r_phase;
            r_clk   <= ~r_phase & ~i_hold;
        end else begin
            r_cnt   <= r_cnt + 1'b1;
        end
    end
endmodule

// File: rtl/scan_chain_driver.sv
// Scan chain controller: shifts slot bytes in, latches, captures io_out, shifts back, responds.
// Define SCAN_CHAIN_DRIVER_TXN_COUNT_EN to add the 16-bit txn_count output.
module scan_chain_driver
    import scan_pkg::*;
#(
    parameter int NUM_SLOTS = 4,
    parameter int CLK_DIV   = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    scan_chain_driver_if.slave bus,
    output logic               scan_clk,
    output logic               scan_data_out,
    output logic               scan_select,
    output logic               scan_latch_en,
    input  logic               scan_data_in
`ifdef SCAN_CHAIN_DRIVER_TXN_COUNT_EN
    ,
    output logic [TXN_CNT_W-1:0] txn_count
`endif
);
    localparam int T  = NUM_SLOTS * SLOT_W;
    localparam int SW = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;
    localparam int BW = $clog2(T + 1);

    state_t            r_state, w_next;
    logic              r_first;
    logic [BW-1:0]     r_bit_cnt;
    logic [SW-1:0]     r_slot;
    logic              r_sdo;
    logic              r_rsp_valid;
    logic [SLOT_W-1:0] r_rsp_data;
    logic [SLOT_W-1:0] r_shadow [NUM_SLOTS];
    logic [T-1:0]      r_chain;
    logic [T-1:0]      w_stream;
    logic [SLOT_W-1:0] w_ret_byte;
    logic              w_accept, w_gen_en, w_hold, w_rise, w_fall;
    logic              w_last_bit, w_slot_ok, w_req_slot_ok;

    assign w_accept      = (r_state == ST_IDLE) && bus.req_valid;
    assign w_last_bit    = (r_bit_cnt == BW'(T - 1));
    assign w_slot_ok     = int'(r_slot) < NUM_SLOTS;
    assign w_req_slot_ok = int'(bus.req_slot) < NUM_SLOTS;
    assign w_hold        = (r_state == ST_LATCH);
    // First SHIFT_IN cycle loads the shadow image, so the divider starts one cycle later
    assign w_gen_en      = ((r_state == ST_SHIFT_IN) && !r_first) || (r_state == ST_LATCH) ||
                           (r_state == ST_CAPTURE) || (r_state == ST_SHIFT_OUT);

    assign bus.req_ready = (r_state == ST_IDLE);
    assign bus.rsp_valid = r_rsp_valid;
    assign bus.rsp_data  = r_rsp_data;
    assign scan_data_out = r_sdo;
    assign scan_select   = (r_state == ST_CAPTURE);
    assign scan_latch_en = (r_state == ST_LATCH);

    scan_clk_gen #(.CLK_DIV(CLK_DIV)) u_clk_gen (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_en       (w_gen_en),
        .i_hold     (w_hold),
        .o_scan_clk (scan_clk),
        .o_rise     (w_rise),
        .o_fall     (w_fall)
    );

    always_comb begin
        w_stream = '0;
        for (int k = 0; k < NUM_SLOTS; k++) w_stream[k*SLOT_W +: SLOT_W] = r_shadow[k];
    end

    always_comb begin
        w_ret_byte = '0;
        if (w_slot_ok) w_ret_byte = r_chain[int'(r_slot)*SLOT_W +: SLOT_W];
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:      if (bus.req_valid)            w_next = ST_SHIFT_IN;
            ST_SHIFT_IN:  if (w_fall && w_last_bit)     w_next = ST_LATCH;
            ST_LATCH:     if (w_fall)                   w_next = ST_CAPTURE;
            ST_CAPTURE:   if (w_fall)                   w_next = ST_SHIFT_OUT;
            ST_SHIFT_OUT: if (w_fall && w_last_bit)     w_next = ST_RESP;
            ST_RESP:      if (r_rsp_valid && bus.rsp_ready) w_next = ST_IDLE;
            default:                                    w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_first     <= 1'b0;
            r_bit_cnt   <= '0;
            r_slot      <= '0;
            r_sdo       <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rsp_data  <= '0;
            for (int k = 0; k < NUM_SLOTS; k++) r_shadow[k] <= '0;
        end else begin
            r_state <= w_next;
            r_first <= w_accept;
            if (w_accept) r_slot <= bus.req_slot;
            if (w_accept && w_req_slot_ok) r_shadow[bus.req_slot] <= bus.req_data;
            if (((r_state == ST_SHIFT_IN) || (r_state == ST_SHIFT_OUT)) && w_fall)
                r_bit_cnt <= w_last_bit ? '0 : r_bit_cnt + 1'b1;
            // Data only moves on the falling strobe so it is stable at the next rise
            if (r_first)
                r_sdo <= w_stream[T-1];
            else if ((r_state == ST_SHIFT_IN) && w_fall)
                r_sdo <= w_last_bit ? 1'b0 : r_chain[T-2];
            if (r_state == ST_RESP) begin
                if (!r_rsp_valid) begin
                    r_rsp_valid <= 1'b1;
                    r_rsp_data  <= w_ret_byte;
                end else if (bus.rsp_ready) begin
                    r_rsp_valid <= 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (r_first)
            r_chain <= w_stream;
        else if ((r_state == ST_SHIFT_IN) && w_fall)
            r_chain <= {r_chain[T-2:0], 1'b0};
        else if ((r_state == ST_SHIFT_OUT) && w_rise)
            r_chain <= {r_chain[T-2:0], scan_data_in};
    end

`ifdef SCAN_CHAIN_DRIVER_TXN_COUNT_EN
    logic [TXN_CNT_W-1:0] r_txn_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                             r_txn_count <= '0;
        else if (r_rsp_valid && bus.rsp_ready)  r_txn_count <= r_txn_count + 1'b1;
    end

    assign txn_count = r_txn_count;
`endif
endmodule

// File: tb/tb_scan_chain_driver.sv
// Directed bench for scan_chain_driver with a behavioural chain (io_out = ~io_in per slot).
module tb_scan_chain_driver;
    import scan_pkg::*;

    localparam int T4 = 32;
    localparam int T3 = 24;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    scan_chain_driver_if #(.NUM_SLOTS(4)) bus4 ();
    scan_chain_driver_if #(.NUM_SLOTS(3)) bus3 ();

    logic sclk4, sdo4, ssel4, slat4, sdi4;
    logic sclk3, sdo3, ssel3, slat3, sdi3;
`ifdef SCAN_CHAIN_DRIVER_TXN_COUNT_EN
    logic [15:0] txn4, txn3;
`endif

    scan_chain_driver #(.NUM_SLOTS(4), .CLK_DIV(2)) dut4 (
        .clk(clk), .rst_n(rst_n), .bus(bus4.slave),
        .scan_clk(sclk4), .scan_data_out(sdo4), .scan_select(ssel4),
        .scan_latch_en(slat4), .scan_data_in(sdi4)
`ifdef SCAN_CHAIN_DRIVER_TXN_COUNT_EN
        , .txn_count(txn4)
`endif
    );

    scan_chain_driver #(.NUM_SLOTS(3), .CLK_DIV(2)) dut3 (
        .clk(clk), .rst_n(rst_n), .bus(bus3.slave),
        .scan_clk(sclk3), .scan_data_out(sdo3), .scan_select(ssel3),
        .scan_latch_en(slat3), .scan_data_in(sdi3)
`ifdef SCAN_CHAIN_DRIVER_TXN_COUNT_EN
        , .txn_count(txn3)
`endif
    );

    // Chain models: slot k occupies bits [8k+7:8k], slot 0 nearest scan_data_out
    logic [T4-1:0] chain4 = '0, latched4 = '0;
    logic [T3-1:0] chain3 = '0, latched3 = '0;
    int rise4 = 0;
    int rise3 = 0;

    always @(posedge sclk4) begin
        rise4++;
        if (ssel4) chain4 <= ~latched4;
        else       chain4 <= {chain4[T4-2:0], sdo4};
    end
    always @(posedge slat4) latched4 <= chain4;
    assign sdi4 = chain4[T4-1];

    always @(posedge sclk3) begin
        rise3++;
        if (ssel3) chain3 <= ~latched3;
        else       chain3 <= {chain3[T3-2:0], sdo3};
    end
    always @(posedge slat3) latched3 <= chain3;
    assign sdi3 = chain3[T3-1];

    task automatic apply_reset();
        @(negedge clk);
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic req4(input logic [1:0] slot, input logic [7:0] data, output int lat);
        @(negedge clk);
        bus4.req_valid = 1'b1;
        bus4.req_slot  = slot;
        bus4.req_data  = data;
        @(posedge clk);
        #1;
        bus4.req_valid = 1'b0;
        lat = 0;
        while (lat < 1000 && bus4.rsp_valid !== 1'b1) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic req3(input logic [1:0] slot, input logic [7:0] data, output int lat);
        @(negedge clk);
        bus3.req_valid = 1'b1;
        bus3.req_slot  = slot;
        bus3.req_data  = data;
        @(posedge clk);
        #1;
        bus3.req_valid = 1'b0;
        lat = 0;
        while (lat < 1000 && bus3.rsp_valid !== 1'b1) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic take4();
        @(negedge clk);
        bus4.rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        bus4.rsp_ready = 1'b0;
    endtask

    task automatic take3();
        @(negedge clk);
        bus3.rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        bus3.rsp_ready = 1'b0;
    endtask

    task automatic test_reset();
        int base;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (bus4.req_ready !== 1'b1) begin failures++; $display("FAIL rst_req_ready got=%b exp=1", bus4.req_ready); end
        checks++; if (bus4.rsp_valid !== 1'b0) begin failures++; $display("FAIL rst_rsp_valid got=%b exp=0", bus4.rsp_valid); end
        checks++; if (bus4.rsp_data !== 8'h00) begin failures++; $display("FAIL rst_rsp_data got=%h exp=00", bus4.rsp_data); end
        checks++; if ({sclk4, sdo4, ssel4, slat4} !== 4'b0000) begin failures++; $display("FAIL rst_scan_pins got=%b exp=0000", {sclk4, sdo4, ssel4, slat4}); end
        @(negedge clk);
        rst_n = 1'b1;
        base = rise4;
        repeat (50) @(posedge clk);
        #1;
        checks++; if (rise4 - base !== 0) begin failures++; $display("FAIL idle_scan_clk rises got=%0d exp=0", rise4 - base); end
        checks++; if (bus3.req_ready !== 1'b1) begin failures++; $display("FAIL idle_req_ready3 got=%b exp=1", bus3.req_ready); end
`ifdef SCAN_CHAIN_DRIVER_TXN_COUNT_EN
        checks++; if (txn4 !== 16'd0) begin failures++; $display("FAIL rst_txn_count got=%0d exp=0", txn4); end
`endif
    endtask

    task automatic test_single();
        int lat, base;
        base = rise4;
        req4(2'd2, 8'hA5, lat);
        checks++; if (lat !== 266) begin failures++; $display("FAIL single_latency got=%0d exp=266", lat); end
        checks++; if (latched4 !== 32'h00A5_0000) begin failures++; $display("FAIL single_latched got=%h exp=00a50000", latched4); end
        checks++; if (bus4.rsp_data !== 8'h5A) begin failures++; $display("FAIL single_rsp_data got=%h exp=5a", bus4.rsp_data); end
        checks++; if (rise4 - base !== 2 * T4 + 1) begin failures++; $display("FAIL single_rises got=%0d exp=%0d", rise4 - base, 2 * T4 + 1); end
        checks++; if (bus4.req_ready !== 1'b0) begin failures++; $display("FAIL single_req_ready got=%b exp=0", bus4.req_ready); end
        take4();
        checks++; if ({bus4.rsp_valid, bus4.req_ready} !== 2'b01) begin failures++; $display("FAIL single_after_take got=%b exp=01", {bus4.rsp_valid, bus4.req_ready}); end
    endtask

    task automatic test_two_slots();
        int lat;
        apply_reset();
        req4(2'd0, 8'h3C, lat);
        checks++; if (bus4.rsp_data !== 8'hC3) begin failures++; $display("FAIL two_first_rsp got=%h exp=c3", bus4.rsp_data); end
        take4();
        req4(2'd1, 8'h0F, lat);
        checks++; if (latched4 !== 32'h0000_0F3C) begin failures++; $display("FAIL two_latched got=%h exp=00000f3c", latched4); end
        checks++; if (bus4.rsp_data !== 8'hF0) begin failures++; $display("FAIL two_rsp_data got=%h exp=f0", bus4.rsp_data); end
        checks++; if (lat !== 266) begin failures++; $display("FAIL two_latency got=%0d exp=266", lat); end
        take4();
    endtask

    task automatic test_back_pressure();
        int lat;
        int bad = 0;
        req4(2'd3, 8'h55, lat);
        checks++; if (latched4 !== 32'h5500_0F3C) begin failures++; $display("FAIL bp_latched got=%h exp=55000f3c", latched4); end
        for (int i = 0; i < 100; i++) begin
            @(posedge clk);
            #1;
            if (bus4.rsp_valid !== 1'b1 || bus4.rsp_data !== 8'hAA || bus4.req_ready !== 1'b0) bad++;
        end
        checks++; if (bad !== 0) begin failures++; $display("FAIL bp_hold unstable_cycles got=%0d exp=0", bad); end
        take4();
        checks++; if ({bus4.rsp_valid, bus4.req_ready} !== 2'b01) begin failures++; $display("FAIL bp_complete got=%b exp=01", {bus4.rsp_valid, bus4.req_ready}); end
`ifdef SCAN_CHAIN_DRIVER_TXN_COUNT_EN
        checks++; if (txn4 !== 16'd3) begin failures++; $display("FAIL bp_txn_count got=%0d exp=3", txn4); end
`endif
    endtask

    task automatic test_reset_mid();
        int lat, base, wait_cyc;
        base = rise4;
        @(negedge clk);
        bus4.req_valid = 1'b1;
        bus4.req_slot  = 2'd1;
        bus4.req_data  = 8'h77;
        @(posedge clk);
        #1;
        bus4.req_valid = 1'b0;
        wait_cyc = 0;
        while (wait_cyc < 500 && (rise4 - base) < 10) begin
            @(posedge clk);
            #1;
            wait_cyc++;
        end
        checks++; if ((rise4 - base) !== 10) begin failures++; $display("FAIL mid_reach_bit10 got=%0d exp=10", rise4 - base); end
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++; if ({bus4.req_ready, bus4.rsp_valid, sclk4, sdo4, ssel4, slat4} !== 6'b100000) begin failures++; $display("FAIL mid_reset_outs got=%b exp=100000", {bus4.req_ready, bus4.rsp_valid, sclk4, sdo4, ssel4, slat4}); end
        checks++; if (bus4.rsp_data !== 8'h00) begin failures++; $display("FAIL mid_reset_rsp_data got=%h exp=00", bus4.rsp_data); end
        @(negedge clk);
        rst_n = 1'b1;
        req4(2'd3, 8'h81, lat);
        checks++; if (latched4 !== 32'h8100_0000) begin failures++; $display("FAIL mid_shadow_cleared got=%h exp=81000000", latched4); end
        checks++; if (bus4.rsp_data !== 8'h7E) begin failures++; $display("FAIL mid_rsp_data got=%h exp=7e", bus4.rsp_data); end
        take4();
    endtask

    task automatic test_bad_slot();
        int lat;
`ifdef SCAN_CHAIN_DRIVER_TXN_COUNT_EN
        logic [15:0] base_txn;
`endif
        req3(2'd1, 8'h12, lat);
        checks++; if (lat !== 202) begin failures++; $display("FAIL bad_ok_latency got=%0d exp=202", lat); end
        checks++; if (latched3 !== 24'h00_1200) begin failures++; $display("FAIL bad_ok_latched got=%h exp=001200", latched3); end
        checks++; if (bus3.rsp_data !== 8'hED) begin failures++; $display("FAIL bad_ok_rsp got=%h exp=ed", bus3.rsp_data); end
        take3();
`ifdef SCAN_CHAIN_DRIVER_TXN_COUNT_EN
        base_txn = txn3;
`endif
        req3(2'd3, 8'h99, lat);
        checks++; if (latched3 !== 24'h00_1200) begin failures++; $display("FAIL bad_no_shadow_write got=%h exp=001200", latched3); end
        checks++; if (bus3.rsp_data !== 8'h00) begin failures++; $display("FAIL bad_rsp_data got=%h exp=00", bus3.rsp_data); end
        checks++; if (lat !== 202) begin failures++; $display("FAIL bad_latency got=%0d exp=202", lat); end
        take3();
`ifdef SCAN_CHAIN_DRIVER_TXN_COUNT_EN
        checks++; if (txn3 !== base_txn + 16'd1) begin failures++; $display("FAIL bad_txn_count got=%0d exp=%0d", txn3, base_txn + 16'd1); end
`endif
    endtask

    initial begin
        bus4.req_valid = 1'b0; bus4.req_slot = '0; bus4.req_data = '0; bus4.rsp_ready = 1'b0;
        bus3.req_valid = 1'b0; bus3.req_slot = '0; bus3.req_data = '0; bus3.rsp_ready = 1'b0;
        test_reset();
        test_single();
        test_two_slots();
        test_back_pressure();
        test_reset_mid();
        test_bad_slot();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
